// File: rtl/priority_log2_seq.sv
// priority_log2_seq: multi-cycle priority encoder / floor(log2).
// Scans a WIDTH-bit vector CHUNK bits per clock, LSB-first or MSB-first per request,
// and returns the index of the first set bit found, with valid/ready on both sides.
// Optional feature: define PRIORITY_LOG2_POW2_EN to add the outIsPow2 output.
module priority_log2_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [WIDTH-1:0]           inVector,
    input  logic                       inMsbFirst,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [$clog2(WIDTH)-1:0]   outNumber,
    output logic                       outZero
`ifdef PRIORITY_LOG2_POW2_EN
    ,
    output logic                       outIsPow2
`endif
);

    localparam int unsigned IDX_W  = $clog2(WIDTH);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   vec_q, vec_d;
    logic               msb_q, msb_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [IDX_W-1:0]   num_d;
    logic               zero_d;
    logic               valid_d;
`ifdef PRIORITY_LOG2_POW2_EN
    logic               pow2_d;
`endif

    int unsigned        base;
    int unsigned        hit_idx;
    logic [CHUNK-1:0]   chunk;
    logic               hit;

    // Ready only while idle and out of reset
    assign inReady = (state_q == IDLE) && !rst;

    // State, captured request and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            msb_q     <= 1'b0;
            k_q       <= '0;
            outValid  <= 1'b0;
            outNumber <= '0;
            outZero   <= 1'b0;
`ifdef PRIORITY_LOG2_POW2_EN
            outIsPow2 <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            msb_q     <= msb_d;
            k_q       <= k_d;
            outValid  <= valid_d;
            outNumber <= num_d;
            outZero   <= zero_d;
`ifdef PRIORITY_LOG2_POW2_EN
            outIsPow2 <= pow2_d;
`endif
        end
    end

    // Chunk search and next-state / next-output logic
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        msb_d   = msb_q;
        k_d     = k_q;
        num_d   = outNumber;
        zero_d  = outZero;
`ifdef PRIORITY_LOG2_POW2_EN
        pow2_d  = outIsPow2;
`endif

        // MSB-first walks chunks from the top; the last assignment in the loop wins,
        // so iteration order picks highest (MSB) or lowest (LSB) bit in the chunk.
        base    = msb_q ? (NCHUNK - 1 - 32'(k_q)) * CHUNK : 32'(k_q) * CHUNK;
        chunk   = CHUNK'(vec_q >> base);
        hit     = 1'b0;
        hit_idx = 0;
        for (int i = 0; i < CHUNK; i++) begin
            if (msb_q) begin
                if (chunk[i]) begin
                    hit     = 1'b1;
                    hit_idx = base + 32'(i);
                end
            end else begin
                if (chunk[CHUNK-1-i]) begin
                    hit     = 1'b1;
                    hit_idx = base + 32'(CHUNK - 1 - i);
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (inValid && inReady) begin
                    vec_d   = inVector;
                    msb_d   = inMsbFirst;
                    k_d     = '0;
`ifdef PRIORITY_LOG2_POW2_EN
                    pow2_d  = ($countones(inVector) == 1);
`endif
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    num_d   = IDX_W'(hit_idx);
                    zero_d  = 1'b0;
                    state_d = DONE;
                end else if (k_q == CNT_W'(NCHUNK - 1)) begin
                    num_d   = '0;
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_priority_log2_seq.sv
// Self-checking bench for priority_log2_seq (WIDTH=8/CHUNK=2 plus a WIDTH=32/CHUNK=8 instance).
// Honours PRIORITY_LOG2_POW2_EN when the design is built with it.
module tb_priority_log2_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inValid = 1'b0;
    logic       inReady;
    logic [7:0] inVector = 8'h00;
    logic       inMsbFirst = 1'b0;
    logic       outValid;
    logic       outReady = 1'b0;
    logic [2:0] outNumber;
    logic       outZero;

    logic        inValid2 = 1'b0;
    logic        inReady2;
    logic [31:0] inVector2 = 32'h0;
    logic        inMsbFirst2 = 1'b0;
    logic        outValid2;
    logic        outReady2 = 1'b0;
    logic [4:0]  outNumber2;
    logic        outZero2;

`ifdef PRIORITY_LOG2_POW2_EN
    logic outIsPow2;
    logic outIsPow22;
`endif

    int    pass_cnt = 0;
    int    total_cnt = 0;
    string tag = "init";

    // Expected result of the transaction in flight, used by the compare process
    bit    exp_pending = 1'b0;
    int    exp_num = 0;
    bit    exp_zero = 1'b0;
    bit    exp_pow2 = 1'b0;

    priority_log2_seq #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst(rst),
        .inValid(inValid), .inReady(inReady), .inVector(inVector), .inMsbFirst(inMsbFirst),
        .outValid(outValid), .outReady(outReady), .outNumber(outNumber), .outZero(outZero)
`ifdef PRIORITY_LOG2_POW2_EN
        , .outIsPow2(outIsPow2)
`endif
    );

    priority_log2_seq #(.WIDTH(32), .CHUNK(8)) dut2 (
        .clk(clk), .rst(rst),
        .inValid(inValid2), .inReady(inReady2), .inVector(inVector2), .inMsbFirst(inMsbFirst2),
        .outValid(outValid2), .outReady(outReady2), .outNumber(outNumber2), .outZero(outZero2)
`ifdef PRIORITY_LOG2_POW2_EN
        , .outIsPow2(outIsPow22)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s [%s]: got %0d, expected %0d", name, tag, act, exp);
    endtask

    // Reference: first set bit by plain bit walk; latency from the chunk that holds it
    function automatic void model(input logic [31:0] v, input bit msb, input int w, input int c,
                                  output int num, output bit zero, output int lat);
        num  = 0;
        zero = 1'b1;
        for (int i = 0; i < w; i++) begin
            if (v[i]) begin
                if (zero || msb) num = i;
                zero = 1'b0;
            end
        end
        if (zero) lat = w / c;
        else if (msb) lat = (w / c - 1 - num / c) + 1;
        else lat = num / c + 1;
    endfunction

    // Per-cycle output check against the expected result while a result is meaningful
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_pending && outValid) begin
                check("out_number", int'(outNumber), exp_num);
                check("out_zero", int'(outZero), int'(exp_zero));
`ifdef PRIORITY_LOG2_POW2_EN
                check("out_is_pow2", int'(outIsPow2), int'(exp_pow2));
`endif
            end else if (!exp_pending) begin
                check("no_spurious_valid", int'(outValid), 0);
            end
        end
    end

    // One full request: literal pin of the model, accept, latency, backpressure, handshake
    task automatic run_req(input logic [7:0] v, input bit msb, input int hold,
                           input int lit_num, input bit lit_zero, input int lit_lat);
        int m_num, m_lat, lat;
        bit m_zero, seen;
        tag = $sformatf("%h/%s", v, msb ? "msb" : "lsb");
        model({24'd0, v}, msb, 8, 2, m_num, m_zero, m_lat);
        check("model_num", m_num, lit_num);
        check("model_zero", int'(m_zero), int'(lit_zero));
        check("model_lat", m_lat, lit_lat);
        @(negedge clk);
        check("ready_idle", int'(inReady), 1);
        inValid = 1'b1; inVector = v; inMsbFirst = msb;
        @(posedge clk); #1;
        inValid = 1'b0; inVector = ~v; inMsbFirst = ~msb;
        exp_num = lit_num; exp_zero = lit_zero; exp_pow2 = ($countones(v) == 1);
        exp_pending = 1'b1;
        check("ready_low_scan", int'(inReady), 0);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            seen = outValid;
        end
        check("latency", lat, lit_lat);
        repeat (hold) begin
            @(posedge clk); #1;
            check("valid_held", int'(outValid), 1);
            check("ready_low_done", int'(inReady), 0);
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        exp_pending = 1'b0;
        check("valid_drop", int'(outValid), 0);
        check("ready_back", int'(inReady), 1);
    endtask

    initial begin
        int lat, m_num, m_lat;
        bit m_zero, seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        tag = "reset";
        check("rst_valid", int'(outValid), 0);
        check("rst_number", int'(outNumber), 0);
        check("rst_zero", int'(outZero), 0);
        check("rst_ready", int'(inReady), 0);
        @(negedge clk); rst = 1'b0;
        #1 check("ready_after_rst", int'(inReady), 1);

        // Directed vectors: vector, msb, backpressure cycles, number, zero, latency
        run_req(8'h01, 1'b0, 0, 0, 1'b0, 1);
        run_req(8'h60, 1'b0, 5, 5, 1'b0, 3);
        run_req(8'h60, 1'b1, 0, 6, 1'b0, 1);
        run_req(8'h80, 1'b1, 0, 7, 1'b0, 1);
        run_req(8'h80, 1'b0, 0, 7, 1'b0, 4);
        run_req(8'h0A, 1'b0, 0, 1, 1'b0, 1);
        run_req(8'h0A, 1'b1, 0, 3, 1'b0, 3);
        run_req(8'h24, 1'b1, 2, 5, 1'b0, 2);
        run_req(8'hFF, 1'b1, 5, 7, 1'b0, 1);
        run_req(8'h00, 1'b1, 0, 0, 1'b1, 4);
        run_req(8'h00, 1'b0, 0, 0, 1'b1, 4);

        // Reset mid-scan: outZero still holds 1 from the zero vector and must clear
        tag = "rst_mid_scan";
        @(negedge clk);
        inValid = 1'b1; inVector = 8'h80; inMsbFirst = 1'b0;
        @(posedge clk); #1;
        inValid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(outValid), 0);
        check("mid_rst_zero", int'(outZero), 0);
        check("mid_rst_ready", int'(inReady), 0);
        #2 rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            check("post_rst_no_valid", int'(outValid), 0);
            check("post_rst_idle", int'(inReady), 1);
        end

        // Reset while a result is held in DONE
        tag = "rst_in_done";
        @(negedge clk);
        inValid = 1'b1; inVector = 8'h60; inMsbFirst = 1'b0;
        @(posedge clk); #1;
        inValid = 1'b0;
        exp_num = 5; exp_zero = 1'b0; exp_pow2 = 1'b0; exp_pending = 1'b1;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            seen = outValid;
        end
        check("done_latency", lat, 3);
        check("done_number", int'(outNumber), 5);
        #1 rst = 1'b1;
        exp_pending = 1'b0;
        #1;
        check("done_rst_valid", int'(outValid), 0);
        check("done_rst_number", int'(outNumber), 0);
        check("done_rst_ready", int'(inReady), 0);
        @(negedge clk); rst = 1'b0;
        #1 check("done_rst_release_ready", int'(inReady), 1);

        // Wide instance: 32-bit vector, 8 bits per cycle
        tag = "w32_00010000/lsb";
        model(32'h0001_0000, 1'b0, 32, 8, m_num, m_zero, m_lat);
        check("w32_model_num", m_num, 16);
        check("w32_model_lat", m_lat, 3);
        @(negedge clk);
        check("w32_ready", int'(inReady2), 1);
        inValid2 = 1'b1; inVector2 = 32'h0001_0000; inMsbFirst2 = 1'b0;
        @(posedge clk); #1;
        inValid2 = 1'b0; inVector2 = 32'hFFFF_FFFF;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            seen = outValid2;
        end
        check("w32_latency", lat, 3);
        check("w32_number", int'(outNumber2), 16);
        check("w32_zero", int'(outZero2), 0);
`ifdef PRIORITY_LOG2_POW2_EN
        check("w32_pow2", int'(outIsPow22), 1);
`endif
        outReady2 = 1'b1;
        @(posedge clk); #1;
        outReady2 = 1'b0;
        check("w32_valid_drop", int'(outValid2), 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
